ppl_trace_buffer: RTL and testbench

//   Synthesizable architectural-state tracer for the pipelined MIPS core.
//   It snoops register-file writebacks and records {cycle stamp, PC, reg, data} entries for watched registers

---
 rtl/ppl_trace_buffer.sv | 148 ++++++++++++++
 tb/tb_ppl_trace_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_trace_buffer.sv
// ppl_trace_buffer: architectural-state tracer for the pipelined MIPS core.
// Snoops WB-stage register writes and records {stamp, pc, reg, data} entries for
// watched registers into a circular buffer. The buffer is drained through rd_req/rd_valid.
// A session starts on arm. It can wait for a trigger PC, stop when full or wrap, and
// halts once the cycle budget is spent.
module ppl_trace_buffer #(
  parameter int unsigned               DATA_W   = 32,
  parameter int unsigned               REG_W    = 5,
  parameter int unsigned               DEPTH    = 16,
  parameter int unsigned               STAMP_W  = 16,
  parameter logic [(2**REG_W)-1:0]     REG_MASK = 32'h03FF_FF00,
  parameter int unsigned               MAX_CYC  = 40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 arm,
  input  logic                                 stop_at_full,
  input  logic                                 trig_en,
  input  logic [DATA_W-1:0]                    trig_pc,
  input  logic [DATA_W-1:0]                    pc,
  input  logic                                 wb_en,
  input  logic [REG_W-1:0]                     wb_reg,
  input  logic [DATA_W-1:0]                    wb_data,
  input  logic                                 rd_req,
  output logic                                 rd_valid,
  output logic [STAMP_W+REG_W+2*DATA_W-1:0]    rd_entry,
  output logic [$clog2(DEPTH):0]               count,
  output logic [1:0]                           state,
  output logic                                 overflow,
  output logic                                 halt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = STAMP_W + REG_W + 2 * DATA_W;
  localparam logic [STAMP_W-1:0] HALT_AT = STAMP_W'((MAX_CYC == 0) ? 0 : MAX_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               ovf_q, ovf_d;
  logic               halt_q, halt_d;
  logic               rd_valid_q, rd_valid_d;
  logic [EW-1:0]      rd_entry_q, rd_entry_d;
  logic [EW-1:0]      mem_q [DEPTH];

  logic qual, trig_hit, cap, pop, full, overwrite, running, budget_hit, mem_we;
  logic [EW-1:0] new_entry;

  assign qual       = wb_en & REG_MASK[wb_reg] & (wb_reg != '0);
  assign trig_hit   = (state_q == ARMED) & (pc == trig_pc);
  assign cap        = qual & ((state_q == CAPTURE) | trig_hit);
  assign pop        = rd_req & (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so only an unpopped full push overwrites.
  assign overwrite  = cap & full & ~pop;
  assign running    = (state_q == ARMED) | (state_q == CAPTURE);
  assign budget_hit = (MAX_CYC != 0) & running & (stamp_q == HALT_AT);
  assign mem_we     = cap & ~arm;
  assign new_entry  = {stamp_q, pc, wb_reg, wb_data};

  // Next-state logic for pointers, count, stamp, FSM and read port
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    stamp_d    = stamp_q;
    ovf_d      = ovf_q;
    halt_d     = halt_q;
    rd_valid_d = 1'b0;
    rd_entry_d = rd_entry_q;
    if (arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stamp_d  = '0;
      ovf_d    = 1'b0;
      halt_d   = 1'b0;
      state_d  = trig_en ? ARMED : CAPTURE;
    end else begin
      if (pop) begin
        rd_valid_d = 1'b1;
        rd_entry_d = mem_q[rd_ptr_q];
      end
      if (cap) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop | overwrite) rd_ptr_d = rd_ptr_q + PW'(1);
      if (overwrite) ovf_d = 1'b1;
      if (cap & ~pop & ~full) count_d = count_q + CW'(1);
      else if (pop & ~cap)    count_d = count_q - CW'(1);
      if (running && (stamp_q != '1)) stamp_d = stamp_q + STAMP_W'(1);
      if (trig_hit) state_d = CAPTURE;
      if ((state_q == CAPTURE) && stop_at_full && (count_d == FULL_CNT)) state_d = DONE;
      if (budget_hit) begin
        state_d = DONE;
        halt_d  = 1'b1;
      end
    end
  end

  // Control/status registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      ovf_q      <= 1'b0;
      halt_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stamp_q    <= stamp_d;
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      rd_valid_q <= rd_valid_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= new_entry;
  end

  assign rd_valid = rd_valid_q;
  assign rd_entry = rd_entry_q;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = ovf_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_ppl_trace_buffer.sv
// Testbench for ppl_trace_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized sessions.
module tb_ppl_trace_buffer;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;
  localparam int MAX_CYC = 40;
  localparam int EW      = STAMP_W + REG_W + 2 * DATA_W;
  localparam logic [31:0] REG_MASK = 32'h03FF_FF00;

  logic              clk, rst, arm, stop_at_full, trig_en, wb_en, rd_req;
  logic [DATA_W-1:0] trig_pc, pc, wb_data;
  logic [REG_W-1:0]  wb_reg;
  logic              rd_valid, overflow, halt;
  logic [EW-1:0]     rd_entry;
  logic [4:0]        count;
  logic [1:0]        state;

  ppl_trace_buffer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W),
    .REG_MASK(REG_MASK), .MAX_CYC(MAX_CYC)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop_at_full(stop_at_full), .trig_en(trig_en),
    .trig_pc(trig_pc), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_entry(rd_entry), .count(count),
    .state(state), .overflow(overflow), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: session state, stamp and a plain queue of entries
  int            m_state;
  int            m_stamp;
  logic [EW-1:0] m_q[$];
  logic          m_ovf, m_halt, m_rdv;
  logic [EW-1:0] m_rde;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_stamp = 0; m_q.delete();
    m_ovf = 1'b0; m_halt = 1'b0; m_rdv = 1'b0; m_rde = '0;
  endtask

  task automatic model_step();
    logic qual, trig, cap, pop;
    int   old;
    if (arm) begin
      m_q.delete(); m_ovf = 1'b0; m_halt = 1'b0; m_stamp = 0; m_rdv = 1'b0;
      m_state = trig_en ? 1 : 2;
      return;
    end
    old  = m_state;
    qual = wb_en && REG_MASK[wb_reg] && (wb_reg != 0);
    trig = (old == 1) && (pc == trig_pc);
    cap  = qual && ((old == 2) || trig);
    pop  = rd_req && (m_q.size() > 0);
    m_rdv = pop;
    if (pop) m_rde = m_q.pop_front();
    if (cap) begin
      if (m_q.size() == DEPTH) begin
        m_q.delete(0);
        m_ovf = 1'b1;
      end
      m_q.push_back({16'(m_stamp), pc, wb_reg, wb_data});
    end
    if (trig) m_state = 2;
    if (old == 2 && stop_at_full && m_q.size() == DEPTH) m_state = 3;
    if ((old == 1 || old == 2) && MAX_CYC != 0 && m_stamp == MAX_CYC - 1) begin
      m_state = 3;
      m_halt  = 1'b1;
    end
    if ((old == 1 || old == 2) && m_stamp < 65535) m_stamp++;
  endtask

  // One clock: model follows the edge, inputs may change 2 time units later
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #2;
  endtask

  task automatic idle_in();
    arm = 1'b0; wb_en = 1'b0; rd_req = 1'b0; wb_reg = '0; wb_data = '0; pc = '0;
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [31:0] p);
    wb_en = 1'b1; wb_reg = 5'(r); wb_data = d; pc = p;
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_state",    128'(state),    128'(m_state));
      chk("cmp_count",    128'(count),    128'(m_q.size()));
      chk("cmp_rd_valid", 128'(rd_valid), 128'(m_rdv));
      chk("cmp_rd_entry", 128'(rd_entry), 128'(m_rde));
      chk("cmp_overflow", 128'(overflow), 128'(m_ovf));
      chk("cmp_halt",     128'(halt),     128'(m_halt));
    end
  end

  logic [EW-1:0] held;

  initial begin
    model_reset();
    rst = 1'b1; stop_at_full = 1'b0; trig_en = 1'b0; trig_pc = '0;
    idle_in();
    tick(); tick();
    chk("reset_state", 128'(state), 0);
    chk("reset_count", 128'(count), 0);
    chk("reset_rdv",   128'(rd_valid), 0);
    chk("reset_entry", 128'(rd_entry), 0);
    rst = 1'b0;
    tick();

    // 1: basic capture, $zero ignored, pop timing and hold
    arm = 1'b1; trig_en = 1'b0; stop_at_full = 1'b1;
    tick(); idle_in();
    chk("t1_state", 128'(state), 2);
    tick(); tick();
    wr(8, 32'd5, 32'h40); tick();
    wr(0, 32'd7, 32'h44); tick();
    idle_in();
    chk("t1_count", 128'(count), 1);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("t1_rdv", 128'(rd_valid), 1);
    held = {16'd2, 32'h40, 5'd8, 32'd5};
    chk("t1_entry", 128'(rd_entry), 128'(held));
    chk("t1_count_after_pop", 128'(count), 0);
    tick();
    chk("t1_rdv_pulse", 128'(rd_valid), 0);
    chk("t1_entry_hold", 128'(rd_entry), 128'(held));

    // 2: unmasked register
    wr(4, 32'd9, 32'h48); tick(); idle_in();
    chk("t2_count", 128'(count), 0);

    // 3: stop at full
    arm = 1'b1; stop_at_full = 1'b1; tick(); idle_in();
    for (int i = 1; i <= 20; i++) begin
      wr(8 + (i % 18), 32'(i), 32'(4 * i)); tick();
    end
    idle_in();
    chk("t3_count", 128'(count), 16);
    chk("t3_state", 128'(state), 3);
    chk("t3_ovf",   128'(overflow), 0);
    for (int k = 1; k <= 16; k++) begin
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      chk("t3_pop_valid", 128'(rd_valid), 1);
      chk("t3_pop_data",  128'(rd_entry[31:0]), 128'(k));
    end

    // 4: wrap mode
    arm = 1'b1; stop_at_full = 1'b0; tick(); idle_in();
    for (int i = 1; i <= 20; i++) begin
      wr(8 + (i % 18), 32'(i), 32'(4 * i)); tick();
    end
    idle_in();
    chk("t4_count", 128'(count), 16);
    chk("t4_ovf",   128'(overflow), 1);
    chk("t4_state", 128'(state), 2);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("t4_first_pop", 128'(rd_entry[31:0]), 5);

    // 5: PC trigger
    arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h14; tick(); idle_in();
    chk("t5_armed", 128'(state), 1);
    wr(9, 32'd1, 32'h0C); tick();
    wr(9, 32'd2, 32'h10); tick();
    idle_in();
    chk("t5_no_cap", 128'(count), 0);
    chk("t5_still_armed", 128'(state), 1);
    wr(9, 32'd3, 32'h14); tick(); idle_in();
    chk("t5_triggered", 128'(state), 2);
    chk("t5_count", 128'(count), 1);

    // 6: cycle budget, then reset mid-pop
    arm = 1'b1; trig_en = 1'b0; tick(); idle_in();
    for (int i = 0; i < 39; i++) begin
      if (i >= 3 && i <= 5) wr(9, 32'(i), 32'h100);
      else idle_in();
      tick();
    end
    idle_in();
    chk("t6_pre_state", 128'(state), 2);
    chk("t6_pre_halt",  128'(halt), 0);
    tick();
    chk("t6_state", 128'(state), 3);
    chk("t6_halt",  128'(halt), 1);
    chk("t6_count", 128'(count), 3);
    rd_req = 1'b1; tick();
    chk("t6_pop", 128'(rd_valid), 1);
    rst = 1'b1; model_reset();
    #1;
    chk("t6_async_count", 128'(count), 0);
    tick();
    chk("t6_rst_state", 128'(state), 0);
    chk("t6_rst_halt",  128'(halt), 0);
    chk("t6_rst_entry", 128'(rd_entry), 0);
    chk("t6_rst_rdv",   128'(rd_valid), 0);
    rst = 1'b0; rd_req = 1'b0;
    tick();

    // Randomized sessions against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; model_reset();
        tick();
        rst = 1'b0;
      end
      arm = ($urandom_range(0, 39) == 0);
      if (arm) begin
        stop_at_full = 1'($urandom_range(0, 1));
        trig_en      = 1'($urandom_range(0, 1));
        trig_pc      = 32'($urandom_range(0, 7) * 4);
      end
      pc      = 32'($urandom_range(0, 7) * 4);
      wb_en   = ($urandom_range(0, 2) != 0);
      wb_reg  = 5'($urandom_range(0, 31));
      wb_data = $urandom;
      rd_req  = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_in();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
